// File: rtl/method_test_runner.sv
// method_test_runner: drives a DUT reset pulse, invokes each method channel over
// req/busy/return, checks returns against expected values, and reports a verdict.
//
// Ports:
//   clk, reset    : clock and asynchronous active-high reset
//   start         : one-cycle pulse, begins a run when not running
//   dut_reset     : reset to the DUT(s), held for RESET_CYCLES at run start
//   test_req      : per-channel one-cycle method request
//   test_busy     : per-channel busy from the DUT
//   test_return   : packed returns, channel i at [i*RET_W +: RET_W]
//   expected      : packed expected values, sampled when a channel completes
//   running, done : run in progress / run finished (held until next start)
//   pass          : valid with done, no failures and no timeouts
//   fail_mask     : channels whose return differed from expected
//   timeout_mask  : channels that never completed within TIMEOUT
//   cycle_count   : cycles from start accept to done, saturating
module method_test_runner #(
   parameter int NUM_CH        = 4,
   parameter int RET_W         = 32,
   parameter int RESET_CYCLES  = 6,
   parameter int SETTLE_CYCLES = 4,
   parameter int BUSY_GRACE    = 2,
   parameter int TIMEOUT       = 100000,
   parameter int PARALLEL      = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    dut_reset,
   output logic [NUM_CH-1:0]       test_req,
   input  logic [NUM_CH-1:0]       test_busy,
   input  logic [NUM_CH*RET_W-1:0] test_return,
   input  logic [NUM_CH*RET_W-1:0] expected,
   output logic                    running,
   output logic                    done,
   output logic                    pass,
   output logic [NUM_CH-1:0]       fail_mask,
   output logic [NUM_CH-1:0]       timeout_mask,
   output logic [31:0]             cycle_count
);

   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TO_W   = $clog2(TIMEOUT + 1);
   localparam int GR_W   = $clog2(BUSY_GRACE + 2);
   localparam int PH_MAX = (RESET_CYCLES > SETTLE_CYCLES) ?
                           RESET_CYCLES : SETTLE_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRESET,
      S_SETTLE,
      S_ISSUE,
      S_WAIT,
      S_FINISH
   } state_t;

   state_t            r_state;
   logic [PH_W-1:0]   r_ph;
   logic [CH_W-1:0]   r_ch;
   logic [GR_W-1:0]   r_grace;
   logic [TO_W-1:0]   r_tcnt;
   logic [NUM_CH-1:0] r_cdone;
   logic              r_dut_reset;
   logic [NUM_CH-1:0] r_req;
   logic              r_running;
   logic              r_done;
   logic              r_pass;
   logic [NUM_CH-1:0] r_fail;
   logic [NUM_CH-1:0] r_to;
   logic [31:0]       r_cyc;

   logic [NUM_CH-1:0] w_act;
   logic [NUM_CH-1:0] w_mis;
   logic [NUM_CH-1:0] w_fin;
   logic              w_post;
   logic              w_tout;
   logic              w_all;
   logic              w_last;
   logic [CH_W-1:0]   w_ch_nx;

   always_comb begin
      w_mis = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_mis[i] = test_return[i*RET_W +: RET_W] !=
                    expected[i*RET_W +: RET_W];
      end
   end

   // Channels taking part in the current wait: one in sequential mode,
   // all of them in parallel mode.
   assign w_act   = (PARALLEL != 0) ? '1 : (NUM_CH'(1) << r_ch);
   assign w_post  = (r_grace == GR_W'(BUSY_GRACE));
   // A channel completes on its first non-busy cycle after the grace window.
   assign w_fin   = (w_post ? w_act : '0) & ~r_cdone & ~test_busy;
   // Timeout counts only post-grace cycles; it fires on the TIMEOUT-th one.
   assign w_tout  = w_post && (r_tcnt == TO_W'(TIMEOUT - 1));
   assign w_all   = &(r_cdone | w_fin | ~w_act);
   assign w_last  = (PARALLEL != 0) || (r_ch == CH_W'(NUM_CH - 1));
   assign w_ch_nx = r_ch + CH_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ph        <= '0;
         r_ch        <= '0;
         r_grace     <= '0;
         r_tcnt      <= '0;
         r_cdone     <= '0;
         r_dut_reset <= 1'b1;
         r_req       <= '0;
         r_running   <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail      <= '0;
         r_to        <= '0;
         r_cyc       <= '0;
      end else begin
         if (r_running && (r_cyc != 32'hFFFF_FFFF)) begin
            r_cyc <= r_cyc + 32'd1;
         end
         unique case (r_state)
            S_IDLE: begin
               r_dut_reset <= 1'b0;
               if (start) begin
                  r_state     <= S_DRESET;
                  r_dut_reset <= 1'b1;
                  r_fail      <= '0;
                  r_to        <= '0;
                  r_pass      <= 1'b0;
                  r_done      <= 1'b0;
                  r_cyc       <= '0;
                  r_running   <= 1'b1;
                  r_ph        <= '0;
                  r_ch        <= '0;
               end
            end
            S_DRESET: begin
               if (r_ph == PH_W'(RESET_CYCLES - 1)) begin
                  r_state     <= S_SETTLE;
                  r_dut_reset <= 1'b0;
                  r_ph        <= '0;
               end else begin
                  r_ph <= r_ph + PH_W'(1);
               end
            end
            S_SETTLE: begin
               if (r_ph == PH_W'(SETTLE_CYCLES - 1)) begin
                  r_state <= S_ISSUE;
                  r_req   <= w_act;
                  r_ph    <= '0;
               end else begin
                  r_ph <= r_ph + PH_W'(1);
               end
            end
            S_ISSUE: begin
               r_req   <= '0;
               r_state <= S_WAIT;
               r_grace <= '0;
               r_tcnt  <= '0;
               r_cdone <= '0;
            end
            S_WAIT: begin
               if (!w_post) begin
                  r_grace <= r_grace + GR_W'(1);
               end else begin
                  r_tcnt <= r_tcnt + TO_W'(1);
               end
               r_fail  <= r_fail | (w_fin & w_mis);
               r_cdone <= r_cdone | w_fin;
               if (w_all || w_tout) begin
                  // Completion in the timeout cycle wins over the timeout.
                  if (w_tout) begin
                     r_to <= r_to | (w_act & ~r_cdone & ~w_fin);
                  end
                  if (w_last) begin
                     r_state <= S_FINISH;
                  end else begin
                     r_ch    <= w_ch_nx;
                     r_req   <= NUM_CH'(1) << w_ch_nx;
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_FINISH: begin
               r_pass    <= ~|r_fail & ~|r_to;
               r_done    <= 1'b1;
               r_running <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign dut_reset    = r_dut_reset;
   assign test_req     = r_req;
   assign running      = r_running;
   assign done         = r_done;
   assign pass         = r_pass;
   assign fail_mask    = r_fail;
   assign timeout_mask = r_to;
   assign cycle_count  = r_cyc;

endmodule

// File: tb/tb_method_test_runner.sv
// tb_method_test_runner: directed bench for method_test_runner, one sequential
// and one parallel instance, each driven by a small busy/return DUT model.
module tb_method_test_runner;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start_s = 1'b0;
   logic         start_p = 1'b0;
   logic         dr_s, dr_p;
   logic [3:0]   req_s, req_p;
   logic [3:0]   busy_s = '0;
   logic [3:0]   busy_p = '0;
   logic [127:0] ret_s, exp_s, ret_p, exp_p;
   logic         run_s, run_p, done_s, done_p, pass_s, pass_p;
   logic [3:0]   fm_s, fm_p, tm_s, tm_p;
   logic [31:0]  cc_s, cc_p;

   int total = 0;
   int bad = 0;
   int len_s[4];
   int len_p[4];
   int cnt_s[4];
   int cnt_p[4];
   bit stuck_s[4];
   int drst_s = 0;
   logic [3:0] rlog_s[$];
   logic [3:0] rlog_p[$];

   always #5 clk = ~clk;

   method_test_runner #(.TIMEOUT(50), .PARALLEL(0)) u_seq (
      .clk(clk), .reset(reset), .start(start_s),
      .dut_reset(dr_s), .test_req(req_s), .test_busy(busy_s),
      .test_return(ret_s), .expected(exp_s),
      .running(run_s), .done(done_s), .pass(pass_s),
      .fail_mask(fm_s), .timeout_mask(tm_s), .cycle_count(cc_s)
   );

   method_test_runner #(.TIMEOUT(50), .PARALLEL(1)) u_par (
      .clk(clk), .reset(reset), .start(start_p),
      .dut_reset(dr_p), .test_req(req_p), .test_busy(busy_p),
      .test_return(ret_p), .expected(exp_p),
      .running(run_p), .done(done_p), .pass(pass_p),
      .fail_mask(fm_p), .timeout_mask(tm_p), .cycle_count(cc_p)
   );

   // Method model: busy rises in the req cycle and stays high len cycles.
   initial begin
      for (int i = 0; i < 4; i++) begin
         cnt_s[i] = 0; cnt_p[i] = 0; stuck_s[i] = 1'b0;
         len_s[i] = 10; len_p[i] = 10;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (req_s[i]) cnt_s[i] = len_s[i];
            else if (cnt_s[i] > 0) cnt_s[i]--;
            busy_s[i] = stuck_s[i] || (cnt_s[i] != 0);
            if (req_p[i]) cnt_p[i] = len_p[i];
            else if (cnt_p[i] > 0) cnt_p[i]--;
            busy_p[i] = (cnt_p[i] != 0);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (run_s && dr_s) drst_s++;
         if (req_s != 4'h0) rlog_s.push_back(req_s);
         if (req_p != 4'h0) rlog_p.push_back(req_p);
      end
   end

   function automatic logic [15:0] pk_s();
      logic [15:0] w;
      w = '0;
      for (int j = 0; j < rlog_s.size() && j < 4; j++)
         w[j*4 +: 4] = rlog_s[j];
      return w;
   endfunction

   task automatic cfg_s();
      ret_s = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
      exp_s = ret_s;
      for (int i = 0; i < 4; i++) begin
         len_s[i] = 10;
         stuck_s[i] = 1'b0;
      end
   endtask

   task automatic pulse_s();
      rlog_s.delete();
      drst_s = 0;
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
   endtask

   task automatic pulse_p();
      rlog_p.delete();
      start_p = 1'b1;
      @(negedge clk);
      start_p = 1'b0;
   endtask

   task automatic wait_s(output bit ok);
      int n;
      n = 0;
      while (!done_s && n < 400) begin
         @(negedge clk);
         n++;
      end
      ok = done_s;
   endtask

   task automatic wait_p(output bit ok);
      int n;
      n = 0;
      while (!done_p && n < 400) begin
         @(negedge clk);
         n++;
      end
      ok = done_p;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({dr_s, req_s, run_s, done_s, pass_s} !== 8'b1_0000_000) begin
         bad++;
         $display("FAIL reset_ctl got=%b want=10000000",
                  {dr_s, req_s, run_s, done_s, pass_s});
      end
      total++;
      if ({fm_s, tm_s, cc_s} !== 40'h0) begin
         bad++;
         $display("FAIL reset_stat got=%h want=0", {fm_s, tm_s, cc_s});
      end
      total++;
      if (dr_p !== 1'b1) begin
         bad++;
         $display("FAIL reset_par_dr got=%b want=1", dr_p);
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if ({dr_s, dr_p} !== 2'b00) begin
         bad++;
         $display("FAIL reset_release_dr got=%b want=00", {dr_s, dr_p});
      end
   endtask

   task automatic test_seq_pass();
      bit ok;
      cfg_s();
      pulse_s();
      wait_s(ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL seq_pass_done got=0 want=1");
      end
      total++;
      if ({pass_s, run_s, fm_s, tm_s} !== 10'b10_0000_0000) begin
         bad++;
         $display("FAIL seq_pass_status got=%b want=1000000000",
                  {pass_s, run_s, fm_s, tm_s});
      end
      total++;
      if (cc_s !== 32'd55) begin
         bad++;
         $display("FAIL seq_pass_cycles got=%0d want=55", cc_s);
      end
      total++;
      if (drst_s !== 6) begin
         bad++;
         $display("FAIL seq_dut_reset_len got=%0d want=6", drst_s);
      end
      total++;
      if (rlog_s.size() !== 4 || pk_s() !== 16'h8421) begin
         bad++;
         $display("FAIL seq_req_order got=%0d/%h want=4/8421",
                  rlog_s.size(), pk_s());
      end
   endtask

   task automatic test_start_ignored();
      bit ok;
      cfg_s();
      pulse_s();
      repeat (20) @(negedge clk);
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      wait_s(ok);
      total++;
      if (!ok || cc_s !== 32'd55 || pass_s !== 1'b1) begin
         bad++;
         $display("FAIL start_ignored got=%0d/%0d/%b want=1/55/1",
                  ok, cc_s, pass_s);
      end
   endtask

   task automatic test_seq_fail();
      bit ok;
      cfg_s();
      ret_s[2*32 +: 32] = 32'h5;
      exp_s[2*32 +: 32] = 32'h6;
      pulse_s();
      wait_s(ok);
      total++;
      if (!ok || fm_s !== 4'b0100 || tm_s !== 4'b0000) begin
         bad++;
         $display("FAIL seq_fail_masks got=%0d/%b/%b want=1/0100/0000",
                  ok, fm_s, tm_s);
      end
      total++;
      if (pass_s !== 1'b0) begin
         bad++;
         $display("FAIL seq_fail_pass got=%b want=0", pass_s);
      end
      total++;
      if (pk_s() !== 16'h8421 || cc_s !== 32'd55) begin
         bad++;
         $display("FAIL seq_fail_ch3_ran got=%h/%0d want=8421/55",
                  pk_s(), cc_s);
      end
   endtask

   task automatic test_restart_in_done();
      bit ok;
      total++;
      if (done_s !== 1'b1) begin
         bad++;
         $display("FAIL restart_pre_done got=%b want=1", done_s);
      end
      rlog_s.delete();
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      total++;
      if ({done_s, run_s, fm_s, cc_s} !== {1'b0, 1'b1, 4'h0, 32'h0}) begin
         bad++;
         $display("FAIL restart_clear got=%b/%b/%b/%0d want=0/1/0000/0",
                  done_s, run_s, fm_s, cc_s);
      end
      wait_s(ok);
      total++;
      if (!ok || fm_s !== 4'b0100) begin
         bad++;
         $display("FAIL restart_rerun got=%0d/%b want=1/0100", ok, fm_s);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      cfg_s();
      stuck_s[1] = 1'b1;
      ret_s[1*32 +: 32] = 32'hBAD;
      pulse_s();
      wait_s(ok);
      stuck_s[1] = 1'b0;
      total++;
      if (!ok || tm_s !== 4'b0010 || fm_s !== 4'b0000) begin
         bad++;
         $display("FAIL timeout_masks got=%0d/%b/%b want=1/0010/0000",
                  ok, tm_s, fm_s);
      end
      total++;
      if (pass_s !== 1'b0) begin
         bad++;
         $display("FAIL timeout_pass got=%b want=0", pass_s);
      end
      total++;
      if (cc_s !== 32'd97) begin
         bad++;
         $display("FAIL timeout_cycles got=%0d want=97", cc_s);
      end
      total++;
      if (pk_s() !== 16'h8421) begin
         bad++;
         $display("FAIL timeout_later_ch got=%h want=8421", pk_s());
      end
   endtask

   task automatic test_parallel();
      bit ok;
      logic [3:0] first;
      ret_p = {32'h44, 32'h33, 32'h22, 32'h11};
      exp_p = ret_p;
      len_p[0] = 5; len_p[1] = 20; len_p[2] = 8; len_p[3] = 12;
      pulse_p();
      wait_p(ok);
      first = (rlog_p.size() > 0) ? rlog_p[0] : 4'h0;
      total++;
      if (rlog_p.size() !== 1 || first !== 4'hF) begin
         bad++;
         $display("FAIL par_req got=%0d/%h want=1/f", rlog_p.size(), first);
      end
      total++;
      if (!ok || cc_p !== 32'd32) begin
         bad++;
         $display("FAIL par_cycles got=%0d/%0d want=1/32", ok, cc_p);
      end
      total++;
      if ({pass_p, fm_p, tm_p} !== 9'b1_0000_0000) begin
         bad++;
         $display("FAIL par_status got=%b want=100000000",
                  {pass_p, fm_p, tm_p});
      end
   endtask

   task automatic test_parallel_nobusy();
      bit ok;
      ret_p = {32'h44, 32'h33, 32'h22, 32'h11};
      exp_p = {32'h45, 32'h33, 32'h22, 32'h11};
      len_p[0] = 0; len_p[1] = 3; len_p[2] = 0; len_p[3] = 0;
      pulse_p();
      wait_p(ok);
      total++;
      if (!ok || cc_p !== 32'd15) begin
         bad++;
         $display("FAIL par_nobusy_cycles got=%0d/%0d want=1/15", ok, cc_p);
      end
      total++;
      if ({pass_p, fm_p, tm_p} !== 9'b0_1000_0000) begin
         bad++;
         $display("FAIL par_nobusy_status got=%b want=010000000",
                  {pass_p, fm_p, tm_p});
      end
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      int n;
      cfg_s();
      pulse_s();
      n = 0;
      while (rlog_s.size() < 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (rlog_s.size() < 2) begin
         bad++;
         $display("FAIL midrst_reach_ch1 got=%0d want=2", rlog_s.size());
      end
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      total++;
      if ({dr_s, req_s, run_s, done_s, pass_s} !== 8'b1_0000_000) begin
         bad++;
         $display("FAIL midrst_ctl got=%b want=10000000",
                  {dr_s, req_s, run_s, done_s, pass_s});
      end
      total++;
      if ({fm_s, tm_s, cc_s} !== 40'h0) begin
         bad++;
         $display("FAIL midrst_stat got=%h want=0", {fm_s, tm_s, cc_s});
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      pulse_s();
      wait_s(ok);
      total++;
      if (!ok || pass_s !== 1'b1 || cc_s !== 32'd55 ||
          pk_s() !== 16'h8421) begin
         bad++;
         $display("FAIL midrst_rerun got=%0d/%b/%0d/%h want=1/1/55/8421",
                  ok, pass_s, cc_s, pk_s());
      end
   endtask

   initial begin
      cfg_s();
      ret_p = '0;
      exp_p = '0;
      test_reset();
      test_seq_pass();
      test_start_ignored();
      test_seq_fail();
      test_restart_in_done();
      test_timeout();
      test_parallel();
      test_parallel_nobusy();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
